// File: rtl/colorled_blink_ctrl.sv
// Blink-burst sequencer for the colour-LED toggle interface.
// Issues framed enable strobes and tracks the lamp state it leaves behind.
module colorled_blink_ctrl #(
  parameter int CNT_W     = 24,
  parameter int N_W       = 8,
  parameter int PULSE_LEN = 2
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_on_ticks,
  input  logic [CNT_W-1:0] i_off_ticks,
  input  logic [N_W-1:0]   i_blinks,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_enable_colorled,
  output logic             o_sync_colled,
  output logic             o_led_on
);

  localparam int S  = PULSE_LEN + 2;
  localparam int TW = $clog2(S);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] TOG_ON   = 3'd1;
  localparam logic [2:0] HOLD_ON  = 3'd2;
  localparam logic [2:0] TOG_OFF  = 3'd3;
  localparam logic [2:0] HOLD_OFF = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] on_q, on_d;
  logic [CNT_W-1:0] off_q, off_d;
  logic [N_W-1:0]   rem_q, rem_d;
  logic             abt_q, abt_d;
  logic             led_q, led_d;

  logic             busy;
  logic             tog;
  logic             tog_last;
  logic             tog_flip;
  logic             abt_now;
  logic [CNT_W-1:0] on_eff;
  logic [CNT_W-1:0] off_eff;

  assign busy     = (state_q == TOG_ON) || (state_q == HOLD_ON) ||
                    (state_q == TOG_OFF) || (state_q == HOLD_OFF);
  assign tog      = (state_q == TOG_ON) || (state_q == TOG_OFF);
  assign tog_last = tog && (tcnt_q == TW'(S - 1));
  assign tog_flip = tog && (tcnt_q == TW'(S - 2));
  assign abt_now  = abt_q | i_abort;
  assign on_eff   = (on_q == '0) ? CNT_W'(1) : on_q;
  assign off_eff  = (off_q == '0) ? CNT_W'(1) : off_q;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    hcnt_d  = hcnt_q;
    on_d    = on_q;
    off_d   = off_q;
    rem_d   = rem_q;
    led_d   = led_q;
    // An abort seen anywhere in a burst stays pending until it is honoured.
    abt_d   = busy ? abt_now : 1'b0;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (i_start) begin
          if (i_blinks == '0) begin
            state_d = DONE;
          end else begin
            on_d    = i_on_ticks;
            off_d   = i_off_ticks;
            rem_d   = i_blinks;
            state_d = TOG_ON;
          end
        end
      end
      TOG_ON: begin
        tcnt_d = tcnt_q + TW'(1);
        if (tog_flip) led_d = 1'b1;
        if (tog_last) begin
          tcnt_d = '0;
          if (abt_now) begin
            state_d = TOG_OFF;
          end else begin
            hcnt_d  = on_eff;
            state_d = HOLD_ON;
          end
        end
      end
      HOLD_ON: begin
        hcnt_d = hcnt_q - CNT_W'(1);
        if (abt_now || hcnt_q == CNT_W'(1)) state_d = TOG_OFF;
      end
      TOG_OFF: begin
        tcnt_d = tcnt_q + TW'(1);
        if (tog_flip) led_d = 1'b0;
        if (tog_last) begin
          tcnt_d = '0;
          rem_d  = rem_q - N_W'(1);
          if (abt_now || rem_q == N_W'(1)) begin
            state_d = DONE;
          end else begin
            hcnt_d  = off_eff;
            state_d = HOLD_OFF;
          end
        end
      end
      HOLD_OFF: begin
        hcnt_d = hcnt_q - CNT_W'(1);
        if (abt_now) state_d = DONE;
        else if (hcnt_q == CNT_W'(1)) state_d = TOG_ON;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      hcnt_q  <= '0;
      on_q    <= '0;
      off_q   <= '0;
      rem_q   <= '0;
      abt_q   <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      hcnt_q  <= hcnt_d;
      on_q    <= on_d;
      off_q   <= off_d;
      rem_q   <= rem_d;
      abt_q   <= abt_d;
      led_q   <= led_d;
    end
  end

  assign o_busy            = busy;
  assign o_done            = (state_q == DONE);
  assign o_sync_colled     = tog;
  assign o_enable_colorled = tog && (tcnt_q != '0) && !tog_last;
  assign o_led_on          = led_q;

endmodule

// File: tb/tb_colorled_blink_ctrl.sv
// Bench for colorled_blink_ctrl: random and directed bursts
// against a phase-list model of the expected output trace.
module tb_colorled_blink_ctrl;

  localparam int CNT_W = 24;
  localparam int N_W   = 8;
  localparam int PL    = 2;
  localparam int S     = PL + 2;

  logic             clk;
  logic             aresetn;
  logic             i_start;
  logic             i_abort;
  logic [CNT_W-1:0] i_on_ticks;
  logic [CNT_W-1:0] i_off_ticks;
  logic [N_W-1:0]   i_blinks;
  logic             o_busy;
  logic             o_done;
  logic             o_enable_colorled;
  logic             o_sync_colled;
  logic             o_led_on;

  colorled_blink_ctrl #(
    .CNT_W(CNT_W),
    .N_W(N_W),
    .PULSE_LEN(PL)
  ) dut (
    .clk(clk),
    .aresetn(aresetn),
    .i_start(i_start),
    .i_abort(i_abort),
    .i_on_ticks(i_on_ticks),
    .i_off_ticks(i_off_ticks),
    .i_blinks(i_blinks),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_enable_colorled(o_enable_colorled),
    .o_sync_colled(o_sync_colled),
    .o_led_on(o_led_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // {busy, done, en, sync, led}
  logic [4:0] exp_q[$];
  int         cyc;
  int         ab_at;
  bit         aborted;

  function automatic logic [4:0] obs();
    return {o_busy, o_done, o_enable_colorled, o_sync_colled, o_led_on};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_tog(input bit lit);
    for (int k = 0; k < S; k++) begin
      exp_q.push_back({1'b1, 1'b0, (k >= 1 && k <= PL), 1'b1,
                       (k == S - 1) ? lit : !lit});
      if (cyc == ab_at) aborted = 1;
      cyc++;
    end
  endtask

  task automatic model_hold(input int n, input bit lamp);
    for (int k = 0; k < n; k++) begin
      bit hit;
      exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, lamp});
      hit = (cyc == ab_at);
      cyc++;
      if (hit) begin
        aborted = 1;
        break;
      end
    end
  endtask

  task automatic build(input int on, input int off, input int blinks,
                       input int ab);
    int on_e;
    int off_e;
    on_e  = (on == 0) ? 1 : on;
    off_e = (off == 0) ? 1 : off;
    exp_q.delete();
    cyc     = 1;
    ab_at   = ab;
    aborted = 0;
    for (int b = 1; b <= blinks; b++) begin
      model_tog(1);
      if (!aborted) model_hold(on_e, 1);
      model_tog(0);
      if (aborted || b == blinks) break;
      model_hold(off_e, 0);
      if (aborted) break;
    end
    exp_q.push_back(5'b01000);
  endtask

  task automatic run_burst(input string tag, input int on, input int off,
                           input int blinks, input int ab, input bit junk);
    int n;
    build(on, off, blinks, ab);
    n = exp_q.size();
    @(negedge clk);
    i_start     = 1'b1;
    i_abort     = junk ? 1'($urandom_range(0, 1)) : 1'b0;
    i_on_ticks  = CNT_W'(on);
    i_off_ticks = CNT_W'(off);
    i_blinks    = N_W'(blinks);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, 32'(obs()), 32'(exp_q[i]));
      i_abort = (i + 1 == ab);
      i_start = (junk && i < n - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (junk) begin
        i_on_ticks  = CNT_W'($urandom_range(0, 9));
        i_off_ticks = CNT_W'($urandom_range(0, 9));
        i_blinks    = N_W'($urandom_range(0, 9));
      end
    end
    @(negedge clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    check({tag, "_idle"}, 32'(obs()), 32'd0);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    aresetn     = 1'b0;
    i_start     = 1'b0;
    i_abort     = 1'b0;
    i_on_ticks  = '0;
    i_off_ticks = '0;
    i_blinks    = '0;
    #1;
    check("reset_out", 32'(obs()), 32'd0);
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    check("post_reset", 32'(obs()), 32'd0);

    run_burst("b1_on3", 3, 0, 1, 0, 0);
    run_burst("b3_on2_off5", 2, 5, 3, 0, 0);
    run_burst("b0", 4, 4, 0, 0, 0);
    run_burst("abort_hold_on", 100, 3, 4, 20, 0);
    run_burst("abort_tog_on", 5, 5, 3, 2, 0);
    run_burst("abort_hold_off", 2, 6, 3, 13, 0);
    run_burst("abort_tog_off", 2, 6, 2, 8, 0);
    run_burst("zero_ticks", 0, 0, 3, 0, 0);

    // Reset in the middle of a toggle sequence.
    @(negedge clk);
    i_start     = 1'b1;
    i_on_ticks  = CNT_W'(3);
    i_off_ticks = CNT_W'(3);
    i_blinks    = N_W'(2);
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_tog", 32'(obs()), 32'b10110);
    #2 aresetn = 1'b0;
    #1;
    check("async_reset", 32'(obs()), 32'd0);
    @(negedge clk);
    check("held_reset", 32'(obs()), 32'd0);
    aresetn = 1'b1;
    @(negedge clk);
    check("after_release", 32'(obs()), 32'd0);
    run_burst("post_rst_burst", 1, 2, 2, 0, 1);

    for (int t = 0; t < 40; t++) begin
      int on;
      int off;
      int bl;
      int ab;
      on  = $urandom_range(0, 6);
      off = $urandom_range(0, 6);
      bl  = $urandom_range(0, 4);
      ab  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 50);
      run_burst("rand", on, off, bl, ab, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/colorled_blink_ctrl.md
Name: colorled_blink_ctrl

Overview:
Clocked sequencer that drives the colour-LED toggle interface from the controlling side. It generates the enable strobe and the sync qualifier; the LED stage toggles its lamp on each falling edge of enable that is seen with sync high. The block executes programmable blink bursts (on-time, off-time, count) with a start/busy/done handshake. It also keeps a shadow copy of the lamp state, so the lamp is always left dark at the end of a burst or an abort.

Parameters:
CNT_W, 24, width of on/off period counters (clk cycles)
N_W, 8, width of blink-count input
PULSE_LEN, 2, cycles o_enable_colorled is held high per toggle (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
aresetn  in  1  reset, asynchronous, active-low
i_start  in  1  burst request, sampled only in IDLE
i_abort  in  1  abort request, sampled only while busy
i_on_ticks  in  CNT_W  lamp-lit cycles per blink (0 treated as 1)
i_off_ticks  in  CNT_W  lamp-dark cycles between blinks (0 treated as 1)
i_blinks  in  N_W  number of blinks in burst
o_busy  out  1  burst in progress
o_done  out  1  one-cycle pulse at burst end (normal or abort)
o_enable_colorled  out  1  toggle strobe; falling edge toggles lamp
o_sync_colled  out  1  toggle qualifier, framing each strobe
o_led_on  out  1  shadow lamp state, 1 = lit

Behaviour:
- Reset (async assert, sync release): state IDLE, all outputs 0, counters 0, shadow lamp 0 (dark). This matches the LED stage, which resets dark on the same aresetn.
- Reset mid-burst: outputs go to 0 immediately. No toggle is issued.
- Cycle numbering: cycle n is n rising edges after the edge that accepts i_start.
- Toggle sequence (TOG), S = PULSE_LEN+2 cycles:
  - First cycle: sync=1, en=0 (setup).
  - Next PULSE_LEN cycles: sync=1, en=1.
  - Last cycle: sync=1, en=0 (falling edge); o_led_on inverts in this cycle.
  - Then sync returns to 0.
- Outside TOG, en=0 and sync=0.
- States:
  - IDLE: o_busy=0.
    - i_start=1 with i_blinks=0 -> DONE.
    - i_start=1 with i_blinks>0 -> latch on/off/blinks, go to TOG_ON.
  - TOG_ON: TOG sequence (lamp on) -> HOLD_ON.
  - HOLD_ON: count max(on_ticks,1) cycles -> TOG_OFF.
  - TOG_OFF: TOG sequence (lamp off), then decrement remaining.
    - remaining=0 -> DONE.
    - otherwise -> HOLD_OFF.
  - HOLD_OFF: count max(off_ticks,1) cycles -> TOG_ON.
  - DONE: one cycle; o_done=1, o_busy=0 -> IDLE.
- o_busy=1 in every state except IDLE and DONE.
- Inputs are latched at start; changes while busy are ignored. i_start while busy is ignored (not queued).
- Abort, checked every cycle while busy:
  - In HOLD_ON -> TOG_OFF, then DONE regardless of remaining count.
  - In HOLD_OFF -> DONE.
  - During a TOG sequence: the sequence always completes, then the abort is honoured as above (pending flag).
  - If the lamp ends lit, one TOG_OFF is run first.
  - Invariant: o_led_on=0 whenever o_busy=0.
- Simultaneous i_start and i_abort in IDLE: start accepted, abort ignored.
- Counters saturate-free: down-count from the latched value. A full-scale CNT_W value gives 2^CNT_W-1 hold cycles.
- Burst length, normal completion: blinks*(2S+on) + (blinks-1)*off cycles, then DONE.

Test Plan:
- PULSE_LEN=2, blinks=1, on=3, start at edge 0:
  - Cycles 1-4 sync=1; en=1 in cycles 2-3; o_led_on=1 from cycle 4.
  - HOLD_ON cycles 5-7; TOG_OFF cycles 8-11; o_led_on=0 at cycle 11.
  - o_done=1 at cycle 12; o_busy high cycles 1-11.
- blinks=3, on=2, off=5: exactly 6 en falling edges, all with sync=1. o_led_on alternates; o_done at cycle 3*10+2*5+1=41.
- blinks=0 with start -> o_done at cycle 1; en/sync never assert; o_busy stays 0.
- blinks=4, on=100, abort during first HOLD_ON (cycle 20) -> TOG_OFF at cycles 21-24, o_led_on=0 at 24, o_done at 25; 2 falling edges total.
- Abort asserted during en high of TOG_ON -> sequence completes; lamp lit; immediate TOG_OFF follows, skipping HOLD_ON; ends dark.
- aresetn low at cycle 3 mid-TOG -> all outputs 0 asynchronously; after release, start is accepted normally; i_start pulses while busy produce no extra bursts.
